// File: rtl/data_debounce.sv
// data_debounce: two-flop synchroniser plus counting debouncer with rise/fall strobes.
// Define DEBOUNCE_PULSE_EN to make data a one-cycle press pulse instead of the debounced level.
module data_debounce #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic data,
  output logic rise,
  output logic fall,
  output logic busy
);
  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic s1_q, s2_q, rise_q, rise_d, fall_q, fall_d, done;
  always_comb begin
    done    = cnt_q == LAST;
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: if (s2_q) begin
        state_d = WAIT_HI;
        cnt_d   = ONE;
      end
      WAIT_HI: if (!s2_q) begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end else if (done) begin
        state_d = IDLE_HI;
        cnt_d   = '0;
        rise_d  = 1'b1;
      end else cnt_d = cnt_q + ONE;
      IDLE_HI: if (!s2_q) begin
        state_d = WAIT_LO;
        cnt_d   = ONE;
      end
      WAIT_LO: if (s2_q) begin
        state_d = IDLE_HI;
        cnt_d   = '0;
      end else if (done) begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        fall_d  = 1'b1;
      end else cnt_d = cnt_q + ONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = state_q == WAIT_HI || state_q == WAIT_LO;
`ifdef DEBOUNCE_PULSE_EN
  assign data = rise_q;
`else
  assign data = state_q == IDLE_HI || state_q == WAIT_LO;
`endif
endmodule

// File: tb/tb_data_debounce.sv
// tb_data_debounce: directed and random stimulus against a run-length debounce model.
module tb_data_debounce;
  localparam int N = 4;
  logic clk = 1'b0, rst_n, btn_in, data, rise, fall, busy;
  int errors = 0, checks = 0;
  logic m_s1, m_s2, m_lvl, m_rise, m_fall, s;
  int m_run;
  data_debounce #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .data(data), .rise(rise), .fall(fall), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic ed(logic lvl, logic r);
`ifdef DEBOUNCE_PULSE_EN
    return r;
`else
    return lvl;
`endif
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Level flips once N consecutive synchronised samples disagree with it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0;
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = btn_in; m_rise = 0; m_fall = 0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == N) begin
          m_lvl = s; m_run = 0;
          if (s) m_rise = 1; else m_fall = 1;
        end
      end else m_run = 0;
    end
  end
  always @(negedge clk) begin
    chk("model_data", data, ed(m_lvl, m_rise));
    chk("model_rise", rise, m_rise);
    chk("model_fall", fall, m_fall);
    chk("model_busy", busy, m_run > 0);
    chk("rise_fall_excl", rise & fall, 0);
  end
  initial begin
    int r_edge, r_cnt, d_cnt, f_cnt;
    logic bseq [7] = '{1, 1, 0, 1, 1, 1, 1};
    rst_n = 0; btn_in = 0;
    step(3); rst_n = 1; step(3);
    btn_in = 1; step(4);
    chk("t1_busy_pre", busy, 1);
    rst_n = 0; #1;
    chk("t1_rst_data", data, 0); chk("t1_rst_rise", rise, 0);
    chk("t1_rst_fall", fall, 0); chk("t1_rst_busy", busy, 0);
    @(posedge clk); #1; rst_n = 1;
    step(5); chk("t1_e5_data", data, 0); chk("t1_e5_rise", rise, 0);
    step(1); chk("t1_e6_data", data, ed(1, 1)); chk("t1_e6_rise", rise, 1);
    step(1); chk("t1_e7_rise", rise, 0); chk("t1_e7_data", data, ed(1, 0));
    btn_in = 0;
    step(2); chk("t2_rel_busy2", busy, 0);
    step(1); chk("t2_rel_busy3", busy, 1);
    step(2); chk("t2_rel_fall5", fall, 0);
    step(1); chk("t2_rel_fall6", fall, 1); chk("t2_rel_data6", data, 0);
    step(1); chk("t2_rel_fall7", fall, 0); chk("t2_rel_busy7", busy, 0);
    step(4); btn_in = 1;
    step(2); chk("t2_busy2", busy, 0);
    step(1); chk("t2_busy3", busy, 1);
    step(3); chk("t2_rise6", rise, 1); chk("t2_data6", data, ed(1, 1));
    step(1); chk("t2_rise7", rise, 0);
    btn_in = 0; step(10);
    btn_in = 1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) btn_in = 0;
      step(1);
      chk("t3_data", data, 0); chk("t3_rise", rise, 0);
    end
    chk("t3_busy_end", busy, 0);
    r_edge = 0; r_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      if (i <= 7) btn_in = bseq[i-1];
      step(1);
      if (rise) begin r_cnt++; r_edge = i; end
    end
    chk("t4_rise_cnt", r_cnt, 1); chk("t4_rise_edge", r_edge, 9);
    btn_in = 0; step(10);
    btn_in = 1; step(4);
    chk("t5_busy_pre", busy, 1);
    rst_n = 0; #1;
    chk("t5_rst_busy", busy, 0); chk("t5_rst_data", data, 0);
    @(posedge clk); #1; rst_n = 1;
    step(2); chk("t5_busy2", busy, 0);
    step(1); chk("t5_busy3", busy, 1);
    step(2); chk("t5_data5", data, 0);
    step(1); chk("t5_data6", data, ed(1, 1)); chk("t5_rise6", rise, 1);
    btn_in = 0; step(10);
    btn_in = 1; d_cnt = 0; r_cnt = 0;
    repeat (20) begin step(1); d_cnt += int'(data); r_cnt += int'(rise); end
    chk("t6_press_data_cycles", d_cnt, ed(1, 0) ? 15 : 1);
    chk("t6_press_rises", r_cnt, 1);
    btn_in = 0; d_cnt = 0; f_cnt = 0;
    repeat (20) begin step(1); d_cnt += int'(data); f_cnt += int'(fall); end
    chk("t6_rel_data_cycles", d_cnt, ed(1, 0) ? 5 : 0);
    chk("t6_rel_falls", f_cnt, 1);
    repeat (400) begin
      btn_in = 1'($urandom_range(0, 1));
      step($urandom_range(1, 7));
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 0; #2; rst_n = 1;
      end
    end
    repeat (12) begin btn_in = ~btn_in; step(1); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
